// File: rtl/adc_axis_pkg.sv
// Shared sample type and defaults for the ADC capture to band-pass filter stream path.
package adc_axis_pkg;

  localparam int unsigned SAMPLE_W          = 12;
  localparam int unsigned FRAME_LEN_DEFAULT = 64;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/axis_sample_fifo.sv
// Sample FIFO with registered head output; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module axis_sample_fifo #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_req,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic                      push_accept_c,
  output logic                      valid_nxt_c,
  output logic                      valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_nxt, rd_ptr_nxt;
  logic [LVL_W-1:0]      level_nxt;
  logic [DATA_WIDTH-1:0] rd_data_nxt;

  assign push_accept_c = push_req & ((level != LVL_W'(DEPTH)) | pop);

  // Next pointers, level and head; forward the incoming sample when it becomes the head.
  always_comb begin
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    level_nxt   = level + LVL_W'(push_accept_c) - LVL_W'(pop);
    valid_nxt_c = 1'b0;
    rd_data_nxt = rd_data;
    if (push_accept_c) wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (pop)           rd_ptr_nxt = rd_ptr + PTR_W'(1);
    valid_nxt_c = (level_nxt != '0);
    if (push_accept_c && (wr_ptr == rd_ptr_nxt)) begin
      rd_data_nxt = push_data;
    end else begin
      rd_data_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      valid   <= 1'b0;
      rd_data <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      level   <= level_nxt;
      valid   <= valid_nxt_c;
      rd_data <= rd_data_nxt;
    end
  end

  // Storage array carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push_accept_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/adc_sample_axis_tx.sv
// ADC sample to AXI-Stream transmitter: enable gating, sample FIFO, frame TLAST
// generation and overflow statistics.
module adc_sample_axis_tx
  import adc_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = SAMPLE_W,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FRAME_LEN      = FRAME_LEN_DEFAULT,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          adc_valid,
  input  logic [DATA_WIDTH-1:0]         adc_data,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow_sticky,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count,
  input  logic                          clear_stats
);

  localparam int unsigned FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

  logic              push_req;
  logic              push_accept_c;
  logic              valid_nxt_c;
  logic              pop;
  logic              drop;
  logic [FCNT_W-1:0] frame_cnt, frame_cnt_nxt;

  assign push_req = adc_valid & enable;
  assign pop      = m_axis_tvalid & m_axis_tready;
  assign drop     = push_req & ~push_accept_c;

  axis_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_req      (push_req),
    .push_data     (adc_data),
    .pop           (pop),
    .push_accept_c (push_accept_c),
    .valid_nxt_c   (valid_nxt_c),
    .valid         (m_axis_tvalid),
    .rd_data       (m_axis_tdata),
    .level         (fifo_level)
  );

  // Frame position advances only on handshakes, so frames span enable gaps.
  always_comb begin
    frame_cnt_nxt = frame_cnt;
    if (pop) begin
      frame_cnt_nxt = (frame_cnt == FCNT_LAST) ? '0 : frame_cnt + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      frame_cnt    <= frame_cnt_nxt;
      m_axis_tlast <= valid_nxt_c & (frame_cnt_nxt == FCNT_LAST);
    end
  end

  // Drop statistics; a clear wins over a drop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_sticky <= 1'b0;
      drop_count      <= '0;
    end else if (clear_stats) begin
      overflow_sticky <= 1'b0;
      drop_count      <= '0;
    end else if (drop) begin
      overflow_sticky <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_adc_sample_axis_tx.sv
// Bench for adc_sample_axis_tx: queue-based reference model, randomized stalls and data.
module tb_adc_sample_axis_tx;

  localparam int DEPTH   = 8;
  localparam int FL      = 4;
  localparam int S_DEPTH = 2;
  localparam int S_MAX   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        enable = 1'b0, adc_valid = 1'b0, tready = 1'b0, clear_stats = 1'b0;
  logic [11:0] adc_data = '0;
  logic        tvalid, tlast, sticky;
  logic [11:0] tdata;
  logic [3:0]  level;
  logic [15:0] drops;

  logic        s_enable = 1'b0, s_valid = 1'b0, s_tready = 1'b1, s_clear = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_tvalid, s_tlast, s_sticky;
  logic [11:0] s_tdata;
  logic [1:0]  s_level;
  logic [3:0]  s_drops;

  int total = 0;
  int bad   = 0;

  int m_q[$];
  int m_drops = 0;
  int m_pops  = 0;
  bit m_sticky = 1'b0;
  int s_q[$];
  int s_drops_m = 0;
  bit s_sticky_m = 1'b0;

  adc_sample_axis_tx #(
    .DATA_WIDTH(12), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .DROP_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_valid(adc_valid), .adc_data(adc_data),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .fifo_level(level), .overflow_sticky(sticky),
    .drop_count(drops), .clear_stats(clear_stats)
  );

  adc_sample_axis_tx #(
    .DATA_WIDTH(12), .FIFO_DEPTH(S_DEPTH), .FRAME_LEN(1), .DROP_CNT_WIDTH(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(s_enable), .adc_valid(s_valid), .adc_data(s_data),
    .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready), .m_axis_tdata(s_tdata),
    .m_axis_tlast(s_tlast), .fifo_level(s_level), .overflow_sticky(s_sticky),
    .drop_count(s_drops), .clear_stats(s_clear)
  );

  function automatic int m_head();
    return (m_q.size() != 0) ? m_q[0] : 0;
  endfunction

  function automatic bit m_tlast();
    return (m_q.size() != 0) && ((m_pops % FL) == FL - 1);
  endfunction

  function automatic bit m_mismatch();
    return (tvalid !== (m_q.size() != 0)) || (level !== 4'(m_q.size())) ||
           ((m_q.size() != 0) && (tdata !== 12'(m_head()))) || (tlast !== m_tlast()) ||
           (drops !== 16'(m_drops)) || (sticky !== m_sticky);
  endfunction

  task automatic clear_models();
    m_q.delete(); s_q.delete();
    m_drops = 0; m_pops = 0; m_sticky = 1'b0;
    s_drops_m = 0; s_sticky_m = 1'b0;
  endtask

  // One clock: reference model steps on the edge, outputs are sampled at the falling edge.
  task automatic cyc();
    bit pop, req, acc;
    @(posedge clk);
    if (rst_n) begin
      pop = (m_q.size() != 0) && tready;
      req = adc_valid && enable;
      acc = req && ((m_q.size() < DEPTH) || pop);
      if (pop) begin void'(m_q.pop_front()); m_pops++; end
      if (acc) m_q.push_back(int'(adc_data));
      if (clear_stats) begin m_drops = 0; m_sticky = 1'b0; end
      else if (req && !acc) begin m_sticky = 1'b1; if (m_drops < 65535) m_drops++; end
      pop = (s_q.size() != 0) && s_tready;
      req = s_valid && s_enable;
      acc = req && ((s_q.size() < S_DEPTH) || pop);
      if (pop) void'(s_q.pop_front());
      if (acc) s_q.push_back(int'(s_data));
      if (s_clear) begin s_drops_m = 0; s_sticky_m = 1'b0; end
      else if (req && !acc) begin s_sticky_m = 1'b1; if (s_drops_m < S_MAX) s_drops_m++; end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    enable = 1'b0; adc_valid = 1'b0; tready = 1'b0; clear_stats = 1'b0;
    s_enable = 1'b0; s_valid = 1'b0; s_tready = 1'b1; s_clear = 1'b0;
    #2 rst_n = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tvalid !== 1'b0 || tdata !== 12'h000 || tlast !== 1'b0 || level !== 4'd0 ||
        sticky !== 1'b0 || drops !== 16'd0) begin
      bad++;
      $display("FAIL reset: got v=%b d=%h l=%b lvl=%0d st=%b dc=%0d, want all zero",
               tvalid, tdata, tlast, level, sticky, drops);
    end
    total++;
    if (s_tvalid !== 1'b0 || s_tdata !== 12'h000 || s_tlast !== 1'b0 || s_level !== 2'd0 ||
        s_sticky !== 1'b0 || s_drops !== 4'd0) begin
      bad++;
      $display("FAIL reset_s: got v=%b d=%h l=%b lvl=%0d st=%b dc=%0d, want all zero",
               s_tvalid, s_tdata, s_tlast, s_level, s_sticky, s_drops);
    end
    clear_models();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    enable = 1'b1; tready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      adc_valid = 1'b1; adc_data = 12'(i);
      cyc();
      total++;
      if (tvalid !== 1'b1 || tdata !== 12'(i) || level !== 4'd1 || m_mismatch()) begin
        bad++;
        $display("FAIL passthrough[%0d]: got v=%b d=%h lvl=%0d l=%b, want v=1 d=%h lvl=1 l=%b",
                 i, tvalid, tdata, level, tlast, 12'(i), m_tlast());
      end
    end
    adc_valid = 1'b0;
    cyc();
    total++;
    if (tvalid !== 1'b0 || level !== 4'd0 || m_mismatch()) begin
      bad++;
      $display("FAIL passthrough_idle: got v=%b lvl=%0d, want v=0 lvl=0", tvalid, level);
    end
  endtask

  task automatic test_overflow();
    tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adc_valid = 1'b1; adc_data = 12'(16 + i);
      cyc();
      total++;
      if (m_mismatch()) begin
        bad++;
        $display("FAIL overflow_fill[%0d]: got v=%b d=%h lvl=%0d dc=%0d, want v=%b d=%h lvl=%0d dc=%0d",
                 i, tvalid, tdata, level, drops, m_q.size() != 0, 12'(m_head()), m_q.size(), m_drops);
      end
    end
    adc_valid = 1'b0;
    total++;
    if (level !== 4'd8 || drops !== 16'd2 || sticky !== 1'b1 || tdata !== 12'h010) begin
      bad++;
      $display("FAIL overflow_stats: got lvl=%0d dc=%0d st=%b d=%h, want lvl=8 dc=2 st=1 d=010",
               level, drops, sticky, tdata);
    end
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (tvalid !== 1'b1 || tdata !== 12'(16 + i)) begin
        bad++;
        $display("FAIL overflow_drain[%0d]: got v=%b d=%h, want v=1 d=%h", i, tvalid, tdata, 12'(16 + i));
      end
      cyc();
    end
    total++;
    if (tvalid !== 1'b0 || m_mismatch()) begin
      bad++;
      $display("FAIL overflow_empty: got v=%b lvl=%0d, want v=0 lvl=0", tvalid, level);
    end
  endtask

  task automatic test_full_pushpop();
    int d_before;
    int last;
    tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      adc_valid = 1'b1; adc_data = 12'($urandom);
      cyc();
    end
    d_before = m_drops;
    tready = 1'b1; adc_valid = 1'b1; adc_data = 12'h7FF;
    cyc();
    adc_valid = 1'b0; tready = 1'b0;
    total++;
    if (level !== 4'd8 || drops !== 16'(d_before) || m_mismatch()) begin
      bad++;
      $display("FAIL full_pushpop: got lvl=%0d dc=%0d, want lvl=8 dc=%0d", level, drops, d_before);
    end
    tready = 1'b1;
    last = -1;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (m_mismatch()) begin
        bad++;
        $display("FAIL full_drain[%0d]: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                 i, tvalid, tdata, tlast, m_q.size() != 0, 12'(m_head()), m_tlast());
      end
      last = int'(tdata);
      cyc();
    end
    total++;
    if (last != 12'h7FF) begin
      bad++;
      $display("FAIL full_last: got %h, want 7ff", last);
    end
  endtask

  task automatic test_tlast();
    int pushed = 0, xfers = 0, n = 0;
    bit stall;
    logic [11:0] pd;
    logic pl;
    apply_reset();
    enable = 1'b1;
    while (xfers < 9 && n < 400) begin
      adc_valid = (pushed < 9) && (m_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      adc_data  = 12'($urandom);
      if (adc_valid) pushed++;
      tready = ($urandom_range(0, 2) != 0);
      if (tvalid && tready) begin
        xfers++;
        total++;
        if (tlast !== ((xfers % FL) == 0)) begin
          bad++;
          $display("FAIL tlast_xfer[%0d]: got l=%b, want l=%b", xfers, tlast, (xfers % FL) == 0);
        end
      end
      stall = tvalid && !tready; pd = tdata; pl = tlast;
      cyc();
      n++;
      total++;
      if (m_mismatch()) begin
        bad++;
        $display("FAIL tlast_model[%0d]: got v=%b d=%h l=%b lvl=%0d, want v=%b d=%h l=%b lvl=%0d",
                 n, tvalid, tdata, tlast, level, m_q.size() != 0, 12'(m_head()), m_tlast(), m_q.size());
      end
      if (stall) begin
        total++;
        if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
          bad++;
          $display("FAIL tlast_stall[%0d]: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   n, tvalid, tdata, tlast, pd, pl);
        end
      end
    end
    adc_valid = 1'b0; tready = 1'b0;
    total++;
    if (xfers != 9) begin
      bad++;
      $display("FAIL tlast_timeout: got %0d transfers, want 9", xfers);
    end
  endtask

  task automatic test_stats();
    enable = 1'b1; tready = 1'b0;
    clear_stats = 1'b1; cyc(); clear_stats = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      adc_valid = 1'b1; adc_data = 12'($urandom);
      cyc();
    end
    total++;
    if (drops !== 16'd3 || sticky !== 1'b1 || m_mismatch()) begin
      bad++;
      $display("FAIL stats_drops: got dc=%0d st=%b, want dc=3 st=1", drops, sticky);
    end
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0; adc_valid = 1'b0;
    total++;
    if (drops !== 16'd0 || sticky !== 1'b0 || level !== 4'd8 || m_mismatch()) begin
      bad++;
      $display("FAIL stats_clear: got dc=%0d st=%b lvl=%0d, want dc=0 st=0 lvl=8", drops, sticky, level);
    end
    tready = 1'b1;
    repeat (DEPTH) cyc();
    tready = 1'b0;
    s_enable = 1'b1; s_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 12'($urandom);
      cyc();
      total++;
      if (s_drops !== 4'(s_drops_m) || s_sticky !== s_sticky_m || s_level !== 2'(s_q.size())) begin
        bad++;
        $display("FAIL sat_step[%0d]: got dc=%0d st=%b lvl=%0d, want dc=%0d st=%b lvl=%0d",
                 i, s_drops, s_sticky, s_level, s_drops_m, s_sticky_m, s_q.size());
      end
    end
    s_valid = 1'b0;
    total++;
    if (s_drops !== 4'hF || s_sticky !== 1'b1 || s_tlast !== 1'b1) begin
      bad++;
      $display("FAIL sat_final: got dc=%0d st=%b l=%b, want dc=15 st=1 l=1", s_drops, s_sticky, s_tlast);
    end
    s_tready = 1'b1;
    for (int i = 0; i < S_DEPTH; i++) begin
      total++;
      if (s_tvalid !== 1'b1 || s_tlast !== 1'b1 || s_tdata !== 12'(s_q[0])) begin
        bad++;
        $display("FAIL len1_drain[%0d]: got v=%b l=%b d=%h, want v=1 l=1 d=%h",
                 i, s_tvalid, s_tlast, s_tdata, 12'(s_q[0]));
      end
      cyc();
    end
    total++;
    if (s_tvalid !== 1'b0 || s_tlast !== 1'b0) begin
      bad++;
      $display("FAIL len1_empty: got v=%b l=%b, want v=0 l=0", s_tvalid, s_tlast);
    end
    s_enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int xfers = 0;
    apply_reset();
    enable = 1'b1; tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      adc_valid = 1'b1; adc_data = 12'($urandom);
      cyc();
    end
    adc_valid = 1'b0; tready = 1'b1;
    repeat (2) cyc();
    tready = 1'b0;
    total++;
    if (level !== 4'd5 || m_mismatch()) begin
      bad++;
      $display("FAIL mid_setup: got lvl=%0d, want lvl=5", level);
    end
    #2 rst_n = 1'b0;
    #1;
    clear_models();
    total++;
    if (tvalid !== 1'b0 || tdata !== 12'h000 || tlast !== 1'b0 || level !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b d=%h l=%b lvl=%0d, want all zero", tvalid, tdata, tlast, level);
    end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1'b1; adc_data = 12'($urandom);
      cyc();
      total++;
      if (tvalid !== 1'b0 || level !== 4'd0 || drops !== 16'd0 || sticky !== 1'b0) begin
        bad++;
        $display("FAIL disabled[%0d]: got v=%b lvl=%0d dc=%0d st=%b, want all zero",
                 i, tvalid, level, drops, sticky);
      end
    end
    enable = 1'b1; tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      adc_valid = (i < 6); adc_data = 12'($urandom);
      if (tvalid && tready) begin
        xfers++;
        total++;
        if (tlast !== (xfers == FL)) begin
          bad++;
          $display("FAIL mid_frame[%0d]: got l=%b, want l=%b", xfers, tlast, xfers == FL);
        end
      end
      cyc();
      total++;
      if (m_mismatch()) begin
        bad++;
        $display("FAIL mid_model[%0d]: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                 i, tvalid, tdata, tlast, m_q.size() != 0, 12'(m_head()), m_tlast());
      end
    end
    adc_valid = 1'b0;
    total++;
    if (xfers != 6) begin
      bad++;
      $display("FAIL mid_count: got %0d transfers, want 6", xfers);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_overflow();
    test_full_pushpop();
    test_tlast();
    test_stats();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
